// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state/counter types and default geometry for the PE controller
package pe_pkg;

   localparam int P_DEF = 6;
   localparam int Q_DEF = 4;
   localparam int S_DEF = 3;
   localparam int QS    = Q_DEF * S_DEF;
   localparam int PQS   = P_DEF * QS;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_IFMAP,
      ST_LOAD_WGHT,
      ST_INIT_PSUM,
      ST_COMPUTE,
      ST_ACC_OUT,
      ST_DONE
   } pe_state_e;

   // CNT_IJ walks i,j only; CNT_IJK walks i,j,k with k innermost; CNT_K walks k only
   typedef enum logic [1:0] {
      CNT_IJ,
      CNT_IJK,
      CNT_K
   } cnt_mode_e;

endpackage

// File: rtl/pe_loop_cnt.sv
// rtl/pe_loop_cnt.sv - nested i/j/k loop counter with running ifmap/weight base addresses
module pe_loop_cnt
   import pe_pkg::*;
#(
   parameter int P                   = P_DEF,
   parameter int Q                   = Q_DEF,
   parameter int S                   = S_DEF,
   parameter int IFMAP_ADDR_BITWIDTH = 4,
   parameter int WGHT_ADDR_BITWIDTH  = 7,
   parameter int PSUM_ADDR_BITWIDTH  = 3
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_en,
   input  cnt_mode_e                      i_mode,
   output logic                           o_last,
   output logic [IFMAP_ADDR_BITWIDTH-1:0] o_ifmap_addr,
   output logic [WGHT_ADDR_BITWIDTH-1:0]  o_wght_addr,
   output logic [PSUM_ADDR_BITWIDTH-1:0]  o_k
);

   localparam logic [IFMAP_ADDR_BITWIDTH-1:0] J_MAX   = IFMAP_ADDR_BITWIDTH'(S - 1);
   localparam logic [IFMAP_ADDR_BITWIDTH-1:0] I_TOP   = IFMAP_ADDR_BITWIDTH'((Q - 1) * S);
   localparam logic [IFMAP_ADDR_BITWIDTH-1:0] S_STEP  = IFMAP_ADDR_BITWIDTH'(S);
   localparam logic [WGHT_ADDR_BITWIDTH-1:0]  QS_STEP = WGHT_ADDR_BITWIDTH'(Q * S);
   localparam logic [PSUM_ADDR_BITWIDTH-1:0]  K_MAX   = PSUM_ADDR_BITWIDTH'(P - 1);

   // i is carried as its ifmap base i*S and k as its weight base k*Q*S
   logic [IFMAP_ADDR_BITWIDTH-1:0] i_base, j;
   logic [PSUM_ADDR_BITWIDTH-1:0]  k;
   logic [WGHT_ADDR_BITWIDTH-1:0]  k_base;
   logic                           i_last, j_last, k_last;
   logic                           step_i, step_j, step_k;

   assign i_last = (i_base == I_TOP);
   assign j_last = (j == J_MAX);
   assign k_last = (k == K_MAX);

   always_comb begin
      step_k = (i_mode != CNT_IJ);
      step_j = (i_mode == CNT_IJ) || ((i_mode == CNT_IJK) && k_last);
      step_i = step_j && j_last;
      case (i_mode)
         CNT_IJ:  o_last = i_last && j_last;
         CNT_IJK: o_last = i_last && j_last && k_last;
         default: o_last = k_last;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         i_base <= '0;
         j      <= '0;
         k      <= '0;
         k_base <= '0;
      end else if (i_en) begin
         if (step_k) begin
            k      <= k_last ? '0 : k + 1'b1;
            k_base <= k_last ? '0 : k_base + QS_STEP;
         end
         if (step_j) j <= j_last ? '0 : j + 1'b1;
         if (step_i) i_base <= i_last ? '0 : i_base + S_STEP;
      end
   end

   assign o_ifmap_addr = i_base + j;
   assign o_wght_addr  = WGHT_ADDR_BITWIDTH'(o_ifmap_addr) + k_base;
   assign o_k          = k;

endmodule

// File: rtl/pe_ctrl.sv
// rtl/pe_ctrl.sv - PE control FSM: scratchpad loads, psum clear, 1-D conv MAC loop, psum drain
module pe_ctrl
   import pe_pkg::*;
#(
   parameter int IFMAP_ADDR_BITWIDTH = 4,
   parameter int WGHT_ADDR_BITWIDTH  = 7,
   parameter int PSUM_ADDR_BITWIDTH  = 3,
   parameter int P                   = P_DEF,
   parameter int Q                   = Q_DEF,
   parameter int S                   = S_DEF
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_start,
   output logic                           o_busy,
   output logic                           o_done,
   input  logic                           i_ifmap_valid,
   output logic                           o_ifmap_ready,
   input  logic                           i_wght_valid,
   output logic                           o_wght_ready,
   input  logic                           i_psum_valid,
   output logic                           o_psum_ready,
   output logic                           o_psum_valid,
   input  logic                           i_psum_ready,
   output logic [IFMAP_ADDR_BITWIDTH-1:0] o_ifmap_ra,
   output logic [IFMAP_ADDR_BITWIDTH-1:0] o_ifmap_wa,
   output logic [WGHT_ADDR_BITWIDTH-1:0]  o_wght_ra,
   output logic [WGHT_ADDR_BITWIDTH-1:0]  o_wght_wa,
   output logic [PSUM_ADDR_BITWIDTH-1:0]  o_psum_ra,
   output logic [PSUM_ADDR_BITWIDTH-1:0]  o_psum_wa,
   output logic                           o_ifmap_we,
   output logic                           o_wght_we,
   output logic                           o_psum_we,
   output logic                           o_acc_sel,
   output logic                           o_rst_psum
);

   if (Q * S > 2 ** IFMAP_ADDR_BITWIDTH) begin : g_bad_ifmap
      $error("pe_ctrl: Q*S does not fit the ifmap spad");
   end
   if (P * Q * S > 2 ** WGHT_ADDR_BITWIDTH) begin : g_bad_wght
      $error("pe_ctrl: P*Q*S does not fit the weight spad");
   end
   if (P > 2 ** PSUM_ADDR_BITWIDTH) begin : g_bad_psum
      $error("pe_ctrl: P does not fit the psum spad");
   end

   pe_state_e                      state, state_nxt;
   cnt_mode_e                      cnt_mode;
   logic                           cnt_en, cnt_last;
   logic [IFMAP_ADDR_BITWIDTH-1:0] ifmap_addr;
   logic [WGHT_ADDR_BITWIDTH-1:0]  wght_addr;
   logic [PSUM_ADDR_BITWIDTH-1:0]  k;

   pe_loop_cnt #(
      .P                   (P),
      .Q                   (Q),
      .S                   (S),
      .IFMAP_ADDR_BITWIDTH (IFMAP_ADDR_BITWIDTH),
      .WGHT_ADDR_BITWIDTH  (WGHT_ADDR_BITWIDTH),
      .PSUM_ADDR_BITWIDTH  (PSUM_ADDR_BITWIDTH)
   ) u_loop_cnt (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_en         (cnt_en),
      .i_mode       (cnt_mode),
      .o_last       (cnt_last),
      .o_ifmap_addr (ifmap_addr),
      .o_wght_addr  (wght_addr),
      .o_k          (k)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Counter control kept apart from the output block so cnt_last never feeds back into its own mode
   always_comb begin
      cnt_mode = CNT_K;
      cnt_en   = 1'b0;
      case (state)
         ST_LOAD_IFMAP: begin cnt_mode = CNT_IJ;  cnt_en = i_ifmap_valid; end
         ST_LOAD_WGHT:  begin cnt_mode = CNT_IJK; cnt_en = i_wght_valid;  end
         ST_INIT_PSUM:  begin cnt_mode = CNT_K;   cnt_en = 1'b1;          end
         ST_COMPUTE:    begin cnt_mode = CNT_IJK; cnt_en = 1'b1;          end
         ST_ACC_OUT:    begin cnt_mode = CNT_K;   cnt_en = i_psum_valid && i_psum_ready; end
         default:       ;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      o_busy        = (state != ST_IDLE);
      o_done        = 1'b0;
      o_ifmap_ready = 1'b0;
      o_wght_ready  = 1'b0;
      o_psum_ready  = 1'b0;
      o_psum_valid  = 1'b0;
      o_ifmap_ra    = '0;
      o_ifmap_wa    = '0;
      o_wght_ra     = '0;
      o_wght_wa     = '0;
      o_psum_ra     = '0;
      o_psum_wa     = '0;
      o_ifmap_we    = 1'b0;
      o_wght_we     = 1'b0;
      o_psum_we     = 1'b0;
      o_acc_sel     = 1'b0;
      o_rst_psum    = 1'b0;
      case (state)
         ST_IDLE: if (i_start) state_nxt = ST_LOAD_IFMAP;
         ST_LOAD_IFMAP: begin
            o_ifmap_ready = 1'b1;
            o_ifmap_we    = i_ifmap_valid;
            o_ifmap_wa    = ifmap_addr;
            if (i_ifmap_valid && cnt_last) state_nxt = ST_LOAD_WGHT;
         end
         ST_LOAD_WGHT: begin
            o_wght_ready = 1'b1;
            o_wght_we    = i_wght_valid;
            o_wght_wa    = wght_addr;
            if (i_wght_valid && cnt_last) state_nxt = ST_INIT_PSUM;
         end
         ST_INIT_PSUM: begin
            o_rst_psum = 1'b1;
            o_acc_sel  = 1'b1;
            o_psum_we  = 1'b1;
            o_psum_wa  = k;
            if (cnt_last) state_nxt = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            o_ifmap_ra = ifmap_addr;
            o_wght_ra  = wght_addr;
            o_psum_ra  = k;
            o_psum_wa  = k;
            o_psum_we  = 1'b1;
            if (cnt_last) state_nxt = ST_ACC_OUT;
         end
         ST_ACC_OUT: begin
            o_psum_ra    = k;
            o_acc_sel    = 1'b1;
            o_psum_valid = i_psum_valid;
            o_psum_ready = i_psum_ready;
            if (i_psum_valid && i_psum_ready && cnt_last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            o_done    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pe_ctrl.sv
// tb/tb_pe_ctrl.sv - randomized bench for pe_ctrl with a behavioural datapath and result model
module tb_pe_ctrl;

   localparam int P    = 6;
   localparam int Q    = 4;
   localparam int S    = 3;
   localparam int QS   = Q * S;
   localparam int PQS  = P * Q * S;
   localparam int BASE = QS + PQS + 2 * P + PQS + 1;

   logic        i_clk, i_rst, i_start;
   logic        o_busy, o_done;
   logic        i_ifmap_valid, o_ifmap_ready, i_wght_valid, o_wght_ready;
   logic        i_psum_valid, o_psum_ready, o_psum_valid, i_psum_ready;
   logic [3:0]  o_ifmap_ra, o_ifmap_wa;
   logic [6:0]  o_wght_ra, o_wght_wa;
   logic [2:0]  o_psum_ra, o_psum_wa;
   logic        o_ifmap_we, o_wght_we, o_psum_we, o_acc_sel, o_rst_psum;
   logic [15:0] i_ifmap_data, i_wght_data;
   logic [31:0] i_psum_data;

   pe_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
      .i_ifmap_valid(i_ifmap_valid), .o_ifmap_ready(o_ifmap_ready),
      .i_wght_valid(i_wght_valid), .o_wght_ready(o_wght_ready),
      .i_psum_valid(i_psum_valid), .o_psum_ready(o_psum_ready),
      .o_psum_valid(o_psum_valid), .i_psum_ready(i_psum_ready),
      .o_ifmap_ra(o_ifmap_ra), .o_ifmap_wa(o_ifmap_wa), .o_wght_ra(o_wght_ra), .o_wght_wa(o_wght_wa),
      .o_psum_ra(o_psum_ra), .o_psum_wa(o_psum_wa), .o_ifmap_we(o_ifmap_we), .o_wght_we(o_wght_we),
      .o_psum_we(o_psum_we), .o_acc_sel(o_acc_sel), .o_rst_psum(o_rst_psum)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Behavioural stand-in for PE_datapath
   logic [15:0] ifmap_spad [16];
   logic [15:0] wght_spad  [128];
   logic [31:0] psum_spad  [8];
   logic [31:0] dp_psum_out;

   always @(posedge i_clk) begin
      if (o_ifmap_we) ifmap_spad[o_ifmap_wa] <= i_ifmap_data;
      if (o_wght_we)  wght_spad[o_wght_wa]   <= i_wght_data;
      if (o_psum_we)  psum_spad[o_psum_wa]   <= o_rst_psum ? 32'd0 :
         psum_spad[o_psum_ra] + 32'(ifmap_spad[o_ifmap_ra]) * 32'(wght_spad[o_wght_ra]);
   end
   assign dp_psum_out = psum_spad[o_psum_ra] + i_psum_data;

   int n_checks = 0;
   int n_fail   = 0;
   int done_pulses = 0;
   int passes_done = 0;

   always @(negedge i_clk) if (o_done) done_pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_pass(input bit fixed, input int gap_word, input int gap_len,
                           input int stall_k, input int stall_len, input int rst_cyc, input int busy_start_cyc);
      int ifm [QS];
      int wq [PQS];
      int exp_out [P];
      int pin, ni, nw, nout, gap_left, stall_left, cyc;
      bit done_seen, aborted;
      pin = fixed ? 10 : int'($urandom_range(0, 255));
      for (int n = 0; n < QS; n++) ifm[n] = fixed ? (n % S) + 1 : int'($urandom_range(0, 15));
      for (int n = 0; n < PQS; n++) wq[n] = fixed ? ((n / P) % S) + 1 : int'($urandom_range(0, 15));
      // Weight word n carries filter k = n % P for ifmap position n / P
      for (int k = 0; k < P; k++) exp_out[k] = pin;
      for (int n = 0; n < PQS; n++) exp_out[n % P] += ifm[n / P] * wq[n];
      ni = 0; nw = 0; nout = 0; cyc = 0; done_seen = 0; aborted = 0;
      gap_left = gap_len; stall_left = stall_len;
      while (!done_seen && !aborted && cyc < 2000) begin
         i_start       = (cyc == 0) || (cyc == busy_start_cyc);
         i_rst         = (cyc == rst_cyc);
         i_ifmap_valid = (ni < QS) && !(ni == gap_word && gap_left > 0);
         i_ifmap_data  = (ni < QS) ? 16'(ifm[ni]) : 16'd0;
         i_wght_valid  = (nw < PQS);
         i_wght_data   = (nw < PQS) ? 16'(wq[nw]) : 16'd0;
         i_psum_valid  = (nout < P);
         i_psum_data   = 32'(pin);
         i_psum_ready  = !(nout == stall_k && stall_left > 0);
         #1;
         if (i_rst) chk("rst_in_compute", 32'(o_psum_we & ~o_acc_sel), 32'd1);
         if (o_ifmap_ready) begin
            chk("ifmap_wa", 32'(o_ifmap_wa), 32'(ni));
            chk("ifmap_we", 32'(o_ifmap_we), 32'(i_ifmap_valid));
            if (i_ifmap_valid) ni++;
            else gap_left--;
         end
         if (o_wght_ready && i_wght_valid) begin
            chk("wght_wa", 32'(o_wght_wa), 32'(nw / P + (nw % P) * QS));
            nw++;
         end
         if (o_acc_sel && !o_rst_psum && !o_psum_we) begin
            chk("acc_psum_ra", 32'(o_psum_ra), 32'(nout));
            chk("acc_psum_valid", 32'(o_psum_valid), 32'(i_psum_valid));
            if (i_psum_ready) begin
               chk("psum_out", dp_psum_out, 32'(exp_out[nout]));
               nout++;
            end else begin
               chk("stall_psum_ready", 32'(o_psum_ready), 32'd0);
               stall_left--;
            end
         end
         if (o_done) begin
            done_seen = 1;
            chk("done_cycle", 32'(cyc), 32'(BASE + gap_len + stall_len));
            chk("out_count", 32'(nout), 32'(P));
         end
         @(posedge i_clk);
         #1;
         if (i_rst) begin
            aborted = 1;
            chk("abort_busy", 32'(o_busy), 32'd0);
            chk("abort_we", 32'({o_ifmap_we, o_wght_we, o_psum_we}), 32'd0);
            i_rst = 1'b0;
         end
         cyc++;
      end
      i_start = 1'b0;
      chk("pass_end", 32'(done_seen | aborted), 32'd1);
      chk("idle_after_pass", 32'(o_busy), 32'd0);
      if (done_seen) passes_done++;
   endtask

   initial begin
      i_rst = 1'b1; i_start = 1'b0;
      i_ifmap_valid = 1'b0; i_wght_valid = 1'b0; i_psum_valid = 1'b0; i_psum_ready = 1'b0;
      i_ifmap_data = '0; i_wght_data = '0; i_psum_data = '0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_ctl", 32'({o_busy, o_done, o_ifmap_ready, o_wght_ready, o_psum_ready, o_psum_valid,
                          o_ifmap_we, o_wght_we, o_psum_we, o_acc_sel, o_rst_psum}), 32'd0);
      chk("rst_addr", 32'({o_ifmap_ra, o_ifmap_wa, o_wght_ra, o_wght_wa, o_psum_ra, o_psum_wa}), 32'd0);
      i_rst = 1'b0;

      run_pass(1, -1, 0, -1, 0, -1, -1);
      run_pass(1, 5, 3, -1, 0, -1, -1);
      run_pass(1, -1, 0, 2, 4, -1, -1);
      run_pass(0, -1, 0, -1, 0, -1, -1);
      run_pass(0, -1, 0, -1, 0, 120, -1);
      run_pass(1, -1, 0, -1, 0, -1, -1);
      run_pass(0, -1, 0, -1, 0, -1, 50);
      for (int r = 0; r < 4; r++)
         run_pass(0, int'($urandom_range(0, QS - 1)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, P - 1)), int'($urandom_range(0, 5)), -1,
                  int'($urandom_range(1, 150)));

      repeat (5) @(posedge i_clk);
      #1;
      chk("done_pulses", 32'(done_pulses), 32'(passes_done));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
